// File: rtl/soc_system_cpu_0_debug_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// soc_system_cpu_0_debug_cmd_sequencer
//
// Purpose:
//   Turns one-cycle debug commands (read, write, set-address, clear-status)
//   into handshaked accesses on the on-chip debug memory. It returns read
//   data and status bits toward the JTAG shift register. After every
//   completed access the word address auto-increments, so block transfers
//   need only one set-address.
//
// Configuration macro:
//   DEBUG_CMD_TIMEOUT_EN - when defined, a 16-bit watchdog aborts an access
//                          that is not acknowledged within TIMEOUT_CYCLES
//                          cycles. When it is undefined, ACCESS waits for
//                          mem_ack indefinitely.
//
// Parameters:
//   ADDR_W         - debug memory word-address width
//   TIMEOUT_CYCLES - access timeout in clk cycles (1..65535)
//
// Ports:
//   clk, reset     - single rising-edge clock, synchronous active-high reset
//   cmd_valid      - one-cycle command strobe
//   cmd_op         - 00 read, 01 write, 10 set-address, 11 clear-status
//   cmd_data       - write data, or the address in [ADDR_W-1:0]
//   cmd_busy       - high while an access is outstanding
//   mem_rd/mem_wr  - request strobes, held until mem_ack
//   mem_addr       - access address
//   mem_wdata      - write data
//   mem_ack        - access completion; mem_rdata is valid in the same cycle
//   mem_rdata      - read data
//   MonDReg        - last read data
//   monitor_ready  - last command completed
//   monitor_error  - sticky error (command collision or timeout)
// ---------------------------------------------------------------------------
module soc_system_cpu_0_debug_cmd_sequencer #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [31:0]       cmd_data,
    output logic              cmd_busy,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SETA  = 2'b10;
    localparam logic [1:0] OP_CLR   = 2'b11;

    // An out-of-range timeout elaborates a named marker block that is
    // visible in the hierarchy, so a bad instance is easy to spot.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_out_of_range
    end

    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic              mem_rd_r;
    logic              mem_wr_r;
    logic [31:0]       mem_wdata_r;
    logic [31:0]       mon_dreg_r;
    logic              monitor_ready_r;
    logic              monitor_error_r;

`ifdef DEBUG_CMD_TIMEOUT_EN
    // The access expires on the edge that ends ACCESS cycle TIMEOUT_CYCLES.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt_r;
`endif

    // Command FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            addr_r          <= '0;
            mem_rd_r        <= 1'b0;
            mem_wr_r        <= 1'b0;
            mem_wdata_r     <= 32'h0000_0000;
            mon_dreg_r      <= 32'h0000_0000;
            monitor_ready_r <= 1'b0;
            monitor_error_r <= 1'b0;
`ifdef DEBUG_CMD_TIMEOUT_EN
            tmo_cnt_r       <= 16'h0000;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A stray mem_ack in IDLE is deliberately ignored.
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_SETA: begin
                                addr_r          <= cmd_data[ADDR_W-1:0];
                                monitor_ready_r <= 1'b1;
                            end
                            OP_READ: begin
                                monitor_ready_r <= 1'b0;
                                monitor_error_r <= 1'b0;
                                mem_rd_r        <= 1'b1;
                                state_r         <= ST_ACCESS;
`ifdef DEBUG_CMD_TIMEOUT_EN
                                tmo_cnt_r       <= 16'h0000;
`endif
                            end
                            OP_WRITE: begin
                                monitor_ready_r <= 1'b0;
                                monitor_error_r <= 1'b0;
                                mem_wdata_r     <= cmd_data;
                                mem_wr_r        <= 1'b1;
                                state_r         <= ST_ACCESS;
`ifdef DEBUG_CMD_TIMEOUT_EN
                                tmo_cnt_r       <= 16'h0000;
`endif
                            end
                            OP_CLR: begin
                                monitor_ready_r <= 1'b0;
                                monitor_error_r <= 1'b0;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_ACCESS: begin
                    // A command that collides with an access is dropped;
                    // only the sticky error records it.
                    if (cmd_valid) begin
                        monitor_error_r <= 1'b1;
                    end
                    if (mem_ack) begin
                        // An ack on the expiry cycle still wins: normal completion.
                        if (mem_rd_r) begin
                            mon_dreg_r <= mem_rdata;
                        end
                        monitor_ready_r <= 1'b1;
                        addr_r          <= addr_r + ADDR_W'(1);
                        mem_rd_r        <= 1'b0;
                        mem_wr_r        <= 1'b0;
                        state_r         <= ST_IDLE;
                    end
`ifdef DEBUG_CMD_TIMEOUT_EN
                    else if (tmo_cnt_r == TMO_LAST) begin
                        // The abort leaves addr and MonDReg untouched.
                        tmo_cnt_r       <= tmo_cnt_r + 16'd1;
                        monitor_error_r <= 1'b1;
                        monitor_ready_r <= 1'b1;
                        mem_rd_r        <= 1'b0;
                        mem_wr_r        <= 1'b0;
                        state_r         <= ST_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 16'd1;
                    end
`endif
                end
                default: begin
                    state_r  <= ST_IDLE;
                    mem_rd_r <= 1'b0;
                    mem_wr_r <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping; everything comes straight from registers.
    always_comb begin
        cmd_busy      = (state_r == ST_ACCESS);
        mem_rd        = mem_rd_r;
        mem_wr        = mem_wr_r;
        mem_addr      = addr_r;
        mem_wdata     = mem_wdata_r;
        MonDReg       = mon_dreg_r;
        monitor_ready = monitor_ready_r;
        monitor_error = monitor_error_r;
    end

endmodule

// File: tb/tb_soc_system_cpu_0_debug_cmd_sequencer.sv
// Directed self-checking bench for soc_system_cpu_0_debug_cmd_sequencer.
module tb_soc_system_cpu_0_debug_cmd_sequencer;

`ifdef DEBUG_CMD_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        cmd_busy;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int err_cnt = 0;
    int chk_cnt = 0;

    soc_system_cpu_0_debug_cmd_sequencer #(
        .ADDR_W        (8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .cmd_busy     (cmd_busy),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .MonDReg      (MonDReg),
        .monitor_ready(monitor_ready),
        .monitor_error(monitor_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (obs !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 32'h0000_0000;
    endtask

    task automatic do_ack(input logic [31:0] rdata);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0000_0000;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},  {31'd0, cmd_busy},      32'd0);
        check_eq({tag, "_rd"},    {31'd0, mem_rd},        32'd0);
        check_eq({tag, "_wr"},    {31'd0, mem_wr},        32'd0);
        check_eq({tag, "_addr"},  {24'd0, mem_addr},      32'd0);
        check_eq({tag, "_wdata"}, mem_wdata,              32'd0);
        check_eq({tag, "_mon"},   MonDReg,                32'd0);
        check_eq({tag, "_rdy"},   {31'd0, monitor_ready}, 32'd0);
        check_eq({tag, "_err"},   {31'd0, monitor_error}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 32'h0000_0000;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0000_0000;
        tick();
        tick();
        reset = 1'b0;
        check_all_zero("rst");

        // Set-address 0x10, then a read acked after 3 strobe cycles.
        do_cmd(2'b10, 32'h0000_0010);
        check_eq("seta_rdy",  {31'd0, monitor_ready}, 32'd1);
        check_eq("seta_addr", {24'd0, mem_addr},      32'h10);
        check_eq("seta_busy", {31'd0, cmd_busy},      32'd0);
        do_cmd(2'b00, 32'h0000_0000);
        check_eq("rd_busy", {31'd0, cmd_busy},      32'd1);
        check_eq("rd_rd",   {31'd0, mem_rd},        32'd1);
        check_eq("rd_wr",   {31'd0, mem_wr},        32'd0);
        check_eq("rd_rdy0", {31'd0, monitor_ready}, 32'd0);
        tick();
        tick();
        check_eq("rd_hold",   {31'd0, mem_rd},   32'd1);
        check_eq("rd_addr_h", {24'd0, mem_addr}, 32'h10);
        do_ack(32'hDEAD_BEEF);
        check_eq("rd_mon",   MonDReg,                32'hDEAD_BEEF);
        check_eq("rd_rdy",   {31'd0, monitor_ready}, 32'd1);
        check_eq("rd_inc",   {24'd0, mem_addr},      32'h11);
        check_eq("rd_drop",  {31'd0, mem_rd},        32'd0);
        check_eq("rd_idle",  {31'd0, cmd_busy},      32'd0);
        check_eq("rd_noerr", {31'd0, monitor_error}, 32'd0);

        // Write at 0xFF; the address wraps and MonDReg keeps the read data.
        do_cmd(2'b10, 32'h0000_00FF);
        do_cmd(2'b01, 32'h1234_5678);
        check_eq("wr_wr",    {31'd0, mem_wr},   32'd1);
        check_eq("wr_rd",    {31'd0, mem_rd},   32'd0);
        check_eq("wr_wdata", mem_wdata,         32'h1234_5678);
        check_eq("wr_addr",  {24'd0, mem_addr}, 32'hFF);
        do_ack(32'hCAFE_F00D);
        check_eq("wr_wrap", {24'd0, mem_addr},      32'h00);
        check_eq("wr_mon",  MonDReg,                32'hDEAD_BEEF);
        check_eq("wr_rdy",  {31'd0, monitor_ready}, 32'd1);
        check_eq("wr_drop", {31'd0, mem_wr},        32'd0);

        // A stray ack while IDLE changes nothing.
        do_ack(32'h1111_1111);
        check_eq("ack_idle_mon",  MonDReg,           32'hDEAD_BEEF);
        check_eq("ack_idle_addr", {24'd0, mem_addr}, 32'h00);
        check_eq("ack_idle_busy", {31'd0, cmd_busy}, 32'd0);

        // A collision during a read sets the error, and the read still completes.
        do_cmd(2'b00, 32'h0000_0000);
        do_cmd(2'b10, 32'h0000_0055);
        check_eq("col_err",  {31'd0, monitor_error}, 32'd1);
        check_eq("col_rd",   {31'd0, mem_rd},        32'd1);
        check_eq("col_addr", {24'd0, mem_addr},      32'h00);
        do_ack(32'hA5A5_A5A5);
        check_eq("col_mon",    MonDReg,                32'hA5A5_A5A5);
        check_eq("col_rdy",    {31'd0, monitor_ready}, 32'd1);
        check_eq("col_sticky", {31'd0, monitor_error}, 32'd1);
        check_eq("col_inc",    {24'd0, mem_addr},      32'h01);
        do_cmd(2'b11, 32'h0000_0000);
        check_eq("clr_rdy", {31'd0, monitor_ready}, 32'd0);
        check_eq("clr_err", {31'd0, monitor_error}, 32'd0);

        // Reset in the second ACCESS cycle, with an ack in the same cycle and one afterward.
        do_cmd(2'b10, 32'h0000_0020);
        do_cmd(2'b00, 32'h0000_0000);
        tick();
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        reset = 1'b0;
        check_all_zero("rst_mid");
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0000_0000;
        check_all_zero("late_ack");

        // Reset wins over a simultaneous command.
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_data  = 32'h0000_0033;
        tick();
        reset     = 1'b0;
        cmd_valid = 1'b0;
        check_eq("rst_prio_addr", {24'd0, mem_addr},      32'h00);
        check_eq("rst_prio_rdy",  {31'd0, monitor_ready}, 32'd0);

`ifdef DEBUG_CMD_TIMEOUT_EN
        // Without an ack, the strobe lasts exactly 4 ACCESS cycles.
        do_cmd(2'b10, 32'h0000_0040);
        do_cmd(2'b00, 32'h0000_0000);
        tick();
        tick();
        tick();
        check_eq("tmo_c4_rd", {31'd0, mem_rd}, 32'd1);
        tick();
        check_eq("tmo_drop", {31'd0, mem_rd},        32'd0);
        check_eq("tmo_busy", {31'd0, cmd_busy},      32'd0);
        check_eq("tmo_err",  {31'd0, monitor_error}, 32'd1);
        check_eq("tmo_rdy",  {31'd0, monitor_ready}, 32'd1);
        check_eq("tmo_addr", {24'd0, mem_addr},      32'h40);
        check_eq("tmo_mon",  MonDReg,                32'h0000_0000);
        // An ack that arrives on the expiry cycle completes normally.
        do_cmd(2'b11, 32'h0000_0000);
        do_cmd(2'b00, 32'h0000_0000);
        tick();
        tick();
        tick();
        do_ack(32'h0BAD_F00D);
        check_eq("tmo_ack_err",  {31'd0, monitor_error}, 32'd0);
        check_eq("tmo_ack_rdy",  {31'd0, monitor_ready}, 32'd1);
        check_eq("tmo_ack_mon",  MonDReg,                32'h0BAD_F00D);
        check_eq("tmo_ack_addr", {24'd0, mem_addr},      32'h41);
`else
        // Without the watchdog, ACCESS waits well beyond TIMEOUT_CYCLES.
        do_cmd(2'b10, 32'h0000_0040);
        do_cmd(2'b00, 32'h0000_0000);
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        check_eq("wait_busy", {31'd0, cmd_busy},      32'd1);
        check_eq("wait_rd",   {31'd0, mem_rd},        32'd1);
        check_eq("wait_err",  {31'd0, monitor_error}, 32'd0);
        do_ack(32'h0BAD_F00D);
        check_eq("wait_mon",  MonDReg,                32'h0BAD_F00D);
        check_eq("wait_addr", {24'd0, mem_addr},      32'h41);
        check_eq("wait_rdy",  {31'd0, monitor_ready}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/soc_system_cpu_0_debug_cmd_sequencer.md
SOC_SYSTEM_CPU_0_DEBUG_CMD_SEQUENCER -- requirements
Module: soc_system_cpu_0_debug_cmd_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: on-chip debug memory word-address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: access-timeout limit in clk cycles, range 1..65535.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1: one-cycle command strobe from the debug-module sysclk decoder.
REQ-006 SHALL have port cmd_op, input, 2: 00 read, 01 write, 10 set-address, 11 clear-status.
REQ-007 SHALL have port cmd_data, input, 32: write data, or address in bits [ADDR_W-1:0] for set-address.
REQ-008 SHALL have port cmd_busy, output, 1: high while an access is outstanding.
REQ-009 SHALL have ports mem_rd and mem_wr, output, 1 each: memory request strobes, held until acknowledged.
REQ-010 SHALL have ports mem_addr (ADDR_W), mem_wdata (32), outputs: access address and write data.
REQ-011 SHALL have ports mem_ack (1) and mem_rdata (32), inputs: access completion and read data, valid in the mem_ack cycle.
REQ-012 SHALL have ports MonDReg (32), monitor_ready (1), monitor_error (1), outputs: returned data and status toward the JTAG shift register.

Function
REQ-013 SHALL implement FSM states IDLE and ACCESS; cmd_busy = (state == ACCESS).
REQ-014 IDLE, cmd_valid, op 10: SHALL load addr <= cmd_data[ADDR_W-1:0], set monitor_ready next cycle, and stay in IDLE.
REQ-015 IDLE, cmd_valid, op 00/01: SHALL clear monitor_ready and monitor_error, latch mem_wdata <= cmd_data for writes, and enter ACCESS with mem_rd/mem_wr asserted on the next cycle.
REQ-016 IDLE, cmd_valid, op 11: SHALL clear monitor_ready and monitor_error next cycle with no memory access.
REQ-017 ACCESS: mem_rd/mem_wr and mem_addr SHALL stay stable until the mem_ack cycle; exactly one strobe high.
REQ-018 On mem_ack in ACCESS: SHALL capture MonDReg <= mem_rdata (reads only), set monitor_ready, increment addr modulo 2^ADDR_W (all-ones wraps to 0), drop strobes, and return to IDLE, all at the next edge.
REQ-019 Read latency SHALL be 1 cycle from cmd_valid to strobe, plus 1 cycle from mem_ack to monitor_ready.
REQ-020 cmd_valid while in ACCESS SHALL be discarded and SHALL set monitor_error (sticky) without disturbing the access.
REQ-021 mem_ack while in IDLE SHALL be ignored.
REQ-022 Writes SHALL leave MonDReg unchanged.

Reset
REQ-023 reset SHALL force state IDLE, addr 0, mem_rd 0, mem_wr 0, mem_wdata 0, MonDReg 0, monitor_ready 0, monitor_error 0, timeout counter 0 at the next edge.
REQ-024 reset asserted mid-access SHALL drop strobes at the next edge; a late mem_ack afterward SHALL be ignored.
REQ-025 reset SHALL take priority over cmd_valid and mem_ack in the same cycle.

Configuration
REQ-026 When DEBUG_CMD_TIMEOUT_EN is defined: a 16-bit counter SHALL clear on ACCESS entry and increment each ACCESS cycle without mem_ack; on reaching TIMEOUT_CYCLES, SHALL drop strobes, set monitor_error and monitor_ready, leave addr and MonDReg unchanged, and return to IDLE.
REQ-027 When DEBUG_CMD_TIMEOUT_EN is defined and mem_ack coincides with expiry, SHALL treat it as normal completion, with no error.
REQ-028 When DEBUG_CMD_TIMEOUT_EN is undefined: no counter logic; ACCESS SHALL wait indefinitely for mem_ack.

Verification
REQ-029 SHALL cover: set-address 0x10, read, mem_ack after 3 cycles with rdata 0xDEADBEEF -> MonDReg 0xDEADBEEF, monitor_ready 1, mem_addr next 0x11.
REQ-030 SHALL cover: set-address 0xFF, write 0x12345678, ack -> mem_wdata 0x12345678 at addr 0xFF, addr wraps to 0x00, MonDReg unchanged.
REQ-031 SHALL cover: cmd_valid during outstanding read -> monitor_error 1, original read completes normally; op 11 then clears both status bits.
REQ-032 SHALL cover: macro defined, TIMEOUT_CYCLES 4, no ack -> strobe dropped after 4 ACCESS cycles, monitor_error 1, addr unchanged; ack on the expiry cycle -> no error.
REQ-033 SHALL cover: reset in the second ACCESS cycle, then mem_ack -> all outputs 0, state IDLE, ack ignored.
